xoodyak_out_serializer: RTL
===========================

Name: xoodyak_out_serializer

Overview:
- Sink for the xoodyak core's result bus.
- On the core's single-cycle sqzdone pulse it captures textout, authdata, verify and opmode into a holding shift register.
- It then streams the result as WORD_W-bit words over a valid/ready interface: text words first, then tag words.
- It sits between the core (encrypt or decrypt instance) and the off-core host/unload path, and is the unloading counterpart of the core's parallel output.

Parameters:
- WORD_W, 32, output word width in bits.
- TEXT_W, 192, width of textout. Must be a multiple of WORD_W.
- TAG_W, 128, width of authdata. Must be a multiple of WORD_W.
- Derived: NWORDS = (TEXT_W+TAG_W)/WORD_W = 10 at defaults. Counter width = clog2(NWORDS).

Ports:
- eph1  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- sqzdone  in  1  single-cycle pulse from core: result valid this cycle.
- textout  in  TEXT_W  cipher/plain text from core.
- authdata  in  TAG_W  tag from core.
- verify  in  1  core verification flag.
- opmode  in  1  core mode (0 encrypt, 1 decrypt).
- dout_ready  in  1  downstream accepts word.
- dout_valid  out  1  word presented.
- dout_data  out  WORD_W  current word.
- dout_last  out  1  final word of the result.
- dout_tag  out  1  current word is from authdata.
- rslt_verify  out  1  verify captured with the current/last result.
- rslt_opmode  out  1  opmode captured with the current/last result.
- busy  out  1  result held, not fully drained.
- overrun  out  1  sticky: sqzdone arrived while busy and was dropped.

Behaviour:
- Reset (async, immediate): state=IDLE, shift register=0, word count=0. All outputs 0.
- States: IDLE, STREAM. busy = dout_valid = (state==STREAM).
- Capture, in IDLE:
  - sqzdone=1 at a posedge loads shreg = {authdata, textout} (textout in the low bits), rslt_verify, rslt_opmode, count=0, state=STREAM.
  - dout_valid is high from the cycle after sqzdone (1-cycle latency).
- Word order: dout_data = shreg[WORD_W-1:0]. LSW of textout first, through the MSW of textout, then LSW of authdata through its MSW.
- Handshake: a transfer occurs at a posedge with dout_valid & dout_ready. Then shreg shifts right by WORD_W (zero fill) and count increments.
- Hold under backpressure: while dout_valid & ~dout_ready, dout_data, dout_last and dout_tag hold stable.
- Flag decode:
  - dout_tag = (count >= TEXT_W/WORD_W).
  - dout_last = (count == NWORDS-1).
- End of stream: a transfer with dout_last returns to IDLE. dout_valid drops next cycle, and dout_data returns to 0.
- Back-to-back capture: sqzdone coincident with the last-word transfer is accepted. A new capture happens, the block stays in STREAM with count=0, and there is no bubble. overrun is not set.
- Dropped pulse: sqzdone in STREAM at any other cycle is ignored. Stream contents are unaffected, and overrun is set to 1, cleared only by reset.
- rslt_verify and rslt_opmode hold until the next accepted capture; they are not cleared on drain.
- Reset mid-stream: the stream is abandoned, all outputs go to 0 asynchronously, and no partial word is replayed after reset release.
- dout_ready with dout_valid=0 has no effect.
- No combinational path from dout_ready to any output.

Test Plan:
1. Reset asserted with dout_ready=1, sqzdone=0 -> all outputs 0. Release reset with 5 idle cycles -> dout_valid stays 0.
2. Capture and drain with dout_ready=1:
   - Stimulus: sqzdone pulse, textout=192'h4d4e4f5051525354555657584142434445464748494a4b4c, authdata=128'h00112233445566778899aabbccddeeff, verify=1, opmode=0.
   - Words on 10 consecutive cycles starting 1 cycle after the pulse: 494a4b4c, 45464748, 41424344, 55565758, 51525354, 4d4e4f50, ccddeeff, 8899aabb, 44556677, 00112233.
   - dout_tag=1 on words 6-9; dout_last only on word 9.
   - rslt_verify=1, rslt_opmode=0.
   - dout_valid=0 on the cycle after word 9.
3. Backpressure: same data, dout_ready toggling 1,0,0,1,... -> each word holds stable while ready=0. Exactly 10 transfers in the same order; busy=1 until the last transfer.
4. Overrun: second sqzdone (new data) while word 3 is presented -> remaining words are still from the first result, overrun=1 and stays 1 until reset, rslt_verify unchanged.
5. Back-to-back: second sqzdone coincident with the last-word transfer -> next cycle dout_valid=1 with the new word 0, count restarted, overrun=0.
6. Async reset asserted mid-cycle while word 4 is valid -> outputs 0 before the next posedge. After release, dout_valid stays 0 until a new sqzdone.

Source files
------------

// File: rtl/xoodyak_out_serializer.sv
// Xoodyak result unloader: captures the core's text/tag on sqzdone and streams
// them out as WORD_W-bit words (text LSW first, then tag) over valid/ready.
module xoodyak_out_serializer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned TEXT_W = 192,
    parameter int unsigned TAG_W  = 128
) (
    input  logic                eph1,
    input  logic                reset,
    input  logic                sqzdone,
    input  logic [TEXT_W-1:0]   textout,
    input  logic [TAG_W-1:0]    authdata,
    input  logic                verify,
    input  logic                opmode,
    input  logic                dout_ready,
    output logic                dout_valid,
    output logic [WORD_W-1:0]   dout_data,
    output logic                dout_last,
    output logic                dout_tag,
    output logic                rslt_verify,
    output logic                rslt_opmode,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned SH_W       = TEXT_W + TAG_W;
    localparam int unsigned NWORDS     = SH_W / WORD_W;
    localparam int unsigned TEXT_WORDS = TEXT_W / WORD_W;
    localparam int unsigned CNT_W      = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [SH_W-1:0]   r_shreg, w_shreg_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic              r_verify, w_verify_nxt;
    logic              r_opmode, w_opmode_nxt;
    logic              r_overrun, w_overrun_nxt;

    logic              w_xfer;
    logic              w_last;
    logic              w_capture;

    assign w_last    = (r_count == CNT_W'(NWORDS - 1));
    assign w_xfer    = (r_state == S_STREAM) && dout_ready;
    // A pulse is only accepted when idle or when it lands on the final transfer.
    assign w_capture = sqzdone && ((r_state == S_IDLE) || (w_xfer && w_last));

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_count   <= '0;
            r_verify  <= 1'b0;
            r_opmode  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_count   <= w_count_nxt;
            r_verify  <= w_verify_nxt;
            r_opmode  <= w_opmode_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_count_nxt   = r_count;
        w_verify_nxt  = r_verify;
        w_opmode_nxt  = r_opmode;
        w_overrun_nxt = r_overrun;

        case (r_state)
            S_IDLE: begin
                if (sqzdone) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_xfer) begin
                    w_shreg_nxt = r_shreg >> WORD_W;
                    w_count_nxt = r_count + CNT_W'(1);
                    if (w_last) begin
                        w_count_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
        endcase

        if (w_capture) begin
            w_shreg_nxt  = {authdata, textout};
            w_count_nxt  = '0;
            w_verify_nxt = verify;
            w_opmode_nxt = opmode;
            w_state_nxt  = S_STREAM;
        end else if (sqzdone) begin
            w_overrun_nxt = 1'b1;
        end
    end

    assign dout_valid  = (r_state == S_STREAM);
    assign busy        = (r_state == S_STREAM);
    assign dout_data   = r_shreg[WORD_W-1:0];
    assign dout_last   = (r_state == S_STREAM) && w_last;
    assign dout_tag    = (r_count >= CNT_W'(TEXT_WORDS));
    assign rslt_verify = r_verify;
    assign rslt_opmode = r_opmode;
    assign overrun     = r_overrun;

endmodule
